// File: rtl/button_press_classifier.sv
// Synchronises and debounces one raw pushbutton, classifies each press as short or long,
// and holds sticky short/long flags until the CPU read path acknowledges them.
module button_press_classifier #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    input  logic clr_short,
    input  logic clr_long,
    output logic press_short,
    output logic press_long,
    output logic pressed
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic             sync1_q, btn_s_q;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_fired_q, long_fired_d;
    logic             pressed_q, pressed_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             set_short, set_long;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        long_fired_d = long_fired_q;
        pressed_d    = pressed_q;
        set_short    = 1'b0;
        set_long     = 1'b0;

        // Long threshold is evaluated alongside the state transitions so a release
        // completing on the same cycle still sees the press as long, never short.
        if ((state_q == HELD || state_q == DEB_REL) && hold_cnt_q == LONG_LAST && !long_fired_q) begin
            set_long     = 1'b1;
            long_fired_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                deb_cnt_d = '0;
                if (btn_s_q) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = CNT_ONE;
                end
            end
            DEB_PRESS: begin
                if (!btn_s_q) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d      = HELD;
                    pressed_d    = 1'b1;
                    hold_cnt_d   = '0;
                    long_fired_d = 1'b0;
                end else begin
                    deb_cnt_d = sat_inc(deb_cnt_q);
                end
            end
            HELD: begin
                hold_cnt_d = sat_inc(hold_cnt_q);
                if (!btn_s_q) begin
                    state_d   = DEB_REL;
                    deb_cnt_d = CNT_ONE;
                end
            end
            DEB_REL: begin
                hold_cnt_d = sat_inc(hold_cnt_q);
                if (btn_s_q) begin
                    state_d = HELD;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d   = IDLE;
                    pressed_d = 1'b0;
                    deb_cnt_d = '0;
                    set_short = !long_fired_q && !set_long;
                end else begin
                    deb_cnt_d = sat_inc(deb_cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase

        short_d = set_short | (short_q & ~clr_short);
        long_d  = set_long  | (long_q  & ~clr_long);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            btn_s_q      <= 1'b0;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            pressed_q    <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= btn_raw;
            btn_s_q      <= sync1_q;
            deb_cnt_q    <= deb_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_fired_q <= long_fired_d;
            pressed_q    <= pressed_d;
            short_q      <= short_d;
            long_q       <= long_d;
        end
    end

    assign press_short = short_q;
    assign press_long  = long_q;
    assign pressed     = pressed_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_press_classifier;

    logic clock = 1'b0;
    logic reset;
    logic btn_raw;
    logic clr_short;
    logic clr_long;
    logic press_short;
    logic press_long;
    logic pressed;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    button_press_classifier #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .CNT_W          (26)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .clr_short  (clr_short),
        .clr_long   (clr_long),
        .press_short(press_short),
        .press_long (press_long),
        .pressed    (pressed)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; btn_raw = 1'b0; clr_short = 1'b0; clr_long = 1'b0;
        tick(2);
        vectors++; if (pressed !== 1'b0) begin miscompares++; $display("FAIL reset_pressed: got %b expected 0", pressed); end
        vectors++; if (press_short !== 1'b0) begin miscompares++; $display("FAIL reset_short: got %b expected 0", press_short); end
        vectors++; if (press_long !== 1'b0) begin miscompares++; $display("FAIL reset_long: got %b expected 0", press_long); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_short_press;
        btn_raw = 1'b1;
        tick(5);
        vectors++; if (pressed !== 1'b0) begin miscompares++; $display("FAIL short_pressed_early: got %b expected 0", pressed); end
        tick(1);
        vectors++; if (pressed !== 1'b1) begin miscompares++; $display("FAIL short_pressed_rise: got %b expected 1", pressed); end
        tick(4);
        btn_raw = 1'b0;
        tick(5);
        vectors++; if (press_short !== 1'b0) begin miscompares++; $display("FAIL short_flag_early: got %b expected 0", press_short); end
        vectors++; if (pressed !== 1'b1) begin miscompares++; $display("FAIL short_pressed_hold: got %b expected 1", pressed); end
        tick(1);
        vectors++; if (press_short !== 1'b1) begin miscompares++; $display("FAIL short_flag_set: got %b expected 1", press_short); end
        vectors++; if (pressed !== 1'b0) begin miscompares++; $display("FAIL short_pressed_fall: got %b expected 0", pressed); end
        vectors++; if (press_long !== 1'b0) begin miscompares++; $display("FAIL short_no_long: got %b expected 0", press_long); end
        clr_short = 1'b1;
        tick(1);
        clr_short = 1'b0;
        vectors++; if (press_short !== 1'b0) begin miscompares++; $display("FAIL short_clear: got %b expected 0", press_short); end
    endtask

    task automatic test_long_press;
        btn_raw = 1'b1;
        tick(6);
        vectors++; if (pressed !== 1'b1) begin miscompares++; $display("FAIL long_pressed_rise: got %b expected 1", pressed); end
        tick(19);
        vectors++; if (press_long !== 1'b0) begin miscompares++; $display("FAIL long_flag_early: got %b expected 0", press_long); end
        tick(1);
        vectors++; if (press_long !== 1'b1) begin miscompares++; $display("FAIL long_flag_set: got %b expected 1", press_long); end
        tick(14);
        btn_raw = 1'b0;
        tick(6);
        vectors++; if (pressed !== 1'b0) begin miscompares++; $display("FAIL long_pressed_fall: got %b expected 0", pressed); end
        vectors++; if (press_short !== 1'b0) begin miscompares++; $display("FAIL long_no_short: got %b expected 0", press_short); end
        vectors++; if (press_long !== 1'b1) begin miscompares++; $display("FAIL long_flag_sticky: got %b expected 1", press_long); end
        clr_long = 1'b1;
        tick(1);
        clr_long = 1'b0;
        vectors++; if (press_long !== 1'b0) begin miscompares++; $display("FAIL long_clear: got %b expected 0", press_long); end
    endtask

    task automatic test_glitch;
        int unsigned lens [2] = '{1, 3};
        for (int k = 0; k < 2; k++) begin
            logic seen = 1'b0;
            btn_raw = 1'b1;
            for (int unsigned c = 0; c < lens[k]; c++) begin
                tick(1);
                seen = seen | pressed | press_short | press_long;
            end
            btn_raw = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick(1);
                seen = seen | pressed | press_short | press_long;
            end
            vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL glitch_len%0d: any output seen high=%b expected 0", lens[k], seen); end
        end
    endtask

    task automatic test_back_to_back;
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(6);
        vectors++; if (press_short !== 1'b1) begin miscompares++; $display("FAIL b2b_first_short: got %b expected 1", press_short); end
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(5);
        clr_short = 1'b1;
        tick(1);
        clr_short = 1'b0;
        vectors++; if (pressed !== 1'b0) begin miscompares++; $display("FAIL b2b_second_done: got %b expected 0", pressed); end
        vectors++; if (press_short !== 1'b1) begin miscompares++; $display("FAIL b2b_set_wins: got %b expected 1", press_short); end
        tick(3);
        clr_long = 1'b1;
        tick(1);
        clr_long = 1'b0;
        vectors++; if (press_long !== 1'b0) begin miscompares++; $display("FAIL b2b_clr_long_idle: got %b expected 0", press_long); end
        vectors++; if (press_short !== 1'b1) begin miscompares++; $display("FAIL b2b_short_kept: got %b expected 1", press_short); end
        clr_short = 1'b1;
        tick(1);
        clr_short = 1'b0;
        vectors++; if (press_short !== 1'b0) begin miscompares++; $display("FAIL b2b_lone_clear: got %b expected 0", press_short); end
    endtask

    task automatic test_release_bounce;
        btn_raw = 1'b1;
        tick(6);
        tick(5);
        btn_raw = 1'b0;
        tick(2);
        btn_raw = 1'b1;
        tick(2);
        vectors++; if (pressed !== 1'b1) begin miscompares++; $display("FAIL bounce_pressed_kept: got %b expected 1", pressed); end
        vectors++; if (press_short !== 1'b0) begin miscompares++; $display("FAIL bounce_no_short: got %b expected 0", press_short); end
        tick(10);
        vectors++; if (press_long !== 1'b0) begin miscompares++; $display("FAIL bounce_long_early: got %b expected 0", press_long); end
        tick(1);
        vectors++; if (press_long !== 1'b1) begin miscompares++; $display("FAIL bounce_long_on_time: got %b expected 1", press_long); end
        tick(5);
        btn_raw = 1'b0;
        tick(6);
        vectors++; if (pressed !== 1'b0) begin miscompares++; $display("FAIL bounce_pressed_fall: got %b expected 0", pressed); end
        vectors++; if (press_short !== 1'b0) begin miscompares++; $display("FAIL bounce_release_no_short: got %b expected 0", press_short); end
        clr_long = 1'b1;
        tick(1);
        clr_long = 1'b0;
    endtask

    task automatic test_reset_mid_press;
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(6);
        vectors++; if (press_short !== 1'b1) begin miscompares++; $display("FAIL rst_pre_short: got %b expected 1", press_short); end
        btn_raw = 1'b1;
        tick(9);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        vectors++; if (pressed !== 1'b0) begin miscompares++; $display("FAIL rst_pressed_cleared: got %b expected 0", pressed); end
        vectors++; if (press_short !== 1'b0) begin miscompares++; $display("FAIL rst_short_cleared: got %b expected 0", press_short); end
        vectors++; if (press_long !== 1'b0) begin miscompares++; $display("FAIL rst_long_cleared: got %b expected 0", press_long); end
        tick(5);
        vectors++; if (pressed !== 1'b0) begin miscompares++; $display("FAIL rst_repress_early: got %b expected 0", pressed); end
        tick(1);
        vectors++; if (pressed !== 1'b1) begin miscompares++; $display("FAIL rst_repress_rise: got %b expected 1", pressed); end
        tick(3);
        btn_raw = 1'b0;
        tick(6);
        vectors++; if (press_short !== 1'b1) begin miscompares++; $display("FAIL rst_repress_short: got %b expected 1", press_short); end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_press();
        test_glitch();
        test_back_to_back();
        test_release_bounce();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
